// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage instruction fields, flush request and the stall/bypass
// selects returned by hazard_ctrl. master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned STAGES = 3
);
    localparam int unsigned FWD_W = $clog2(STAGES + 1);

    logic [5:0]       d_op;
    logic [5:0]       d_func;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_rd;
    logic             flush;
    logic             stall;
    logic [FWD_W-1:0] fwd_rs;
    logic [FWD_W-1:0] fwd_rt;

    modport master (
        output d_op, d_func, d_rs, d_rt, d_rd, flush,
        input  stall, fwd_rs, fwd_rt
    );

    modport slave (
        input  d_op, d_func, d_rs, d_rt, d_rd, flush,
        output stall, fwd_rs, fwd_rt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decodes the D-stage instruction into Tuse/Tnew/dest, tracks in-flight
// writers over STAGES stages after D, and drives the D-stage stall and per-operand
// bypass selects (0 = regfile, k = entry k). stall/fwd are combinational.
// Optional feature macro: CTRL_MDU_EN adds mult/div/mfhi/mflo/mthi/mtlo decode and
// an MDU busy interlock; without it those opcodes decode as nop.
module hazard_ctrl #(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned FWD_W = $clog2(STAGES + 1);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_LOTBZ   = 6'b111110;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_JR      = 6'b001000;
`ifdef CTRL_MDU_EN
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
`endif

    localparam logic [4:0] CP0_MF     = 5'b00000;
    localparam logic [4:0] CP0_MT     = 5'b00100;

    // Reject configurations the counters cannot represent
    if (STAGES == 0 || TNEW_W < 2 || MULT_CYC == 0 || DIV_CYC == 0) begin : g_cfg_check
        $error("hazard_ctrl: STAGES, MULT_CYC, DIV_CYC must be nonzero and TNEW_W >= 2");
    end

    logic [4:0]        dec_dest;
    logic [TNEW_W-1:0] dec_tnew;
    logic              use_rs;
    logic              use_rt;
    logic [TNEW_W-1:0] tuse_rs;
    logic [TNEW_W-1:0] tuse_rt;
`ifdef CTRL_MDU_EN
    logic              is_mdu;
    logic              is_md;
    logic              is_div;
`endif

    // Decode D-stage instruction into destination, Tnew and operand Tuse
    always_comb begin
        dec_dest = 5'd0;
        dec_tnew = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        tuse_rs  = '0;
        tuse_rt  = '0;
`ifdef CTRL_MDU_EN
        is_mdu   = 1'b0;
        is_md    = 1'b0;
        is_div   = 1'b0;
`endif
        case (hz.d_op)
            OP_SPECIAL: begin
                case (hz.d_func)
                    FN_ADD, FN_SUB: begin
                        dec_dest = hz.d_rd;
                        dec_tnew = TNEW_W'(1);
                        use_rs   = 1'b1;
                        tuse_rs  = TNEW_W'(1);
                        use_rt   = 1'b1;
                        tuse_rt  = TNEW_W'(1);
                    end
                    FN_JR: begin
                        use_rs  = 1'b1;
                        tuse_rs = TNEW_W'(0);
                    end
`ifdef CTRL_MDU_EN
                    FN_MULT, FN_DIV, FN_MTHI, FN_MTLO: begin
                        is_mdu  = 1'b1;
                        is_md   = (hz.d_func == FN_MULT) || (hz.d_func == FN_DIV);
                        is_div  = (hz.d_func == FN_DIV);
                        use_rs  = 1'b1;
                        tuse_rs = TNEW_W'(1);
                        use_rt  = 1'b1;
                        tuse_rt = TNEW_W'(1);
                    end
                    FN_MFHI, FN_MFLO: begin
                        is_mdu   = 1'b1;
                        dec_dest = hz.d_rd;
                        dec_tnew = TNEW_W'(1);
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI: begin
                dec_dest = hz.d_rt;
                dec_tnew = TNEW_W'(1);
                use_rs   = 1'b1;
                tuse_rs  = TNEW_W'(1);
            end
            OP_LW, OP_LOTBZ: begin
                dec_dest = hz.d_rt;
                dec_tnew = TNEW_W'(2);
                use_rs   = 1'b1;
                tuse_rs  = TNEW_W'(1);
            end
            OP_SW: begin
                use_rs  = 1'b1;
                tuse_rs = TNEW_W'(1);
                use_rt  = 1'b1;
                tuse_rt = TNEW_W'(2);
            end
            OP_BEQ: begin
                use_rs  = 1'b1;
                tuse_rs = TNEW_W'(0);
                use_rt  = 1'b1;
                tuse_rt = TNEW_W'(0);
            end
            OP_JAL: begin
                dec_dest = 5'd31;
                dec_tnew = TNEW_W'(0);
            end
            OP_COP0: begin
                case (hz.d_rs)
                    CP0_MF: begin
                        dec_dest = hz.d_rt;
                        dec_tnew = TNEW_W'(2);
                    end
                    CP0_MT: begin
                        use_rt  = 1'b1;
                        tuse_rt = TNEW_W'(2);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // In-flight writer table: index i holds entry i+1 (0 = E, 1 = M, 2 = W, ...)
    logic [4:0]        dest_q [STAGES];
    logic [TNEW_W-1:0] tnew_q [STAGES];
    logic [4:0]        dest_d [STAGES];
    logic [TNEW_W-1:0] tnew_d [STAGES];

    logic             reg_stall_c;
    logic             mdu_stall_c;
    logic             stall_c;
    logic [FWD_W-1:0] fwd_rs_c;
    logic [FWD_W-1:0] fwd_rt_c;

    // RAW check against every in-flight writer; bypass only from the youngest match
    always_comb begin
        reg_stall_c = 1'b0;
        fwd_rs_c    = '0;
        fwd_rt_c    = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (use_rs && dest_q[i] != 5'd0 && dest_q[i] == hz.d_rs && tuse_rs < tnew_q[i])
                reg_stall_c = 1'b1;
            if (use_rt && dest_q[i] != 5'd0 && dest_q[i] == hz.d_rt && tuse_rt < tnew_q[i])
                reg_stall_c = 1'b1;
        end
        // Walk oldest to youngest so the youngest match has the final say
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            if (use_rs && dest_q[i] != 5'd0 && dest_q[i] == hz.d_rs)
                fwd_rs_c = (tnew_q[i] == '0) ? FWD_W'(i + 1) : '0;
            if (use_rt && dest_q[i] != 5'd0 && dest_q[i] == hz.d_rt)
                fwd_rt_c = (tnew_q[i] == '0) ? FWD_W'(i + 1) : '0;
        end
    end

    assign stall_c   = reg_stall_c | mdu_stall_c;
    assign hz.stall  = stall_c;
    assign hz.fwd_rs = fwd_rs_c;
    assign hz.fwd_rt = fwd_rt_c;

    // Advance the writer table: flush clears, stall injects a bubble into E
    always_comb begin
        for (int i = 0; i < int'(STAGES); i++) begin
            dest_d[i] = dest_q[i];
            tnew_d[i] = tnew_q[i];
        end
        if (hz.flush) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                dest_d[i] = 5'd0;
                tnew_d[i] = '0;
            end
        end else begin
            for (int i = 1; i < int'(STAGES); i++) begin
                dest_d[i] = dest_q[i-1];
                tnew_d[i] = (tnew_q[i-1] != '0) ? tnew_q[i-1] - TNEW_W'(1) : '0;
            end
            dest_d[0] = stall_c ? 5'd0 : dec_dest;
            tnew_d[0] = stall_c ? '0   : dec_tnew;
        end
    end

    // Writer table registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                dest_q[i] <= 5'd0;
                tnew_q[i] <= '0;
            end
        end else begin
            dest_q <= dest_d;
            tnew_q <= tnew_d;
        end
    end

`ifdef CTRL_MDU_EN
    localparam int unsigned CYC_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned BUSY_W  = $clog2(CYC_MAX + 1);

    logic [BUSY_W-1:0] busy_q;
    logic [BUSY_W-1:0] busy_d;
    logic              md_e1_q;
    logic              md_e1_d;

    assign mdu_stall_c = is_mdu && ((busy_q != '0) || md_e1_q);

    // MDU busy countdown, reloaded when mult/div leaves D; flush leaves it running
    always_comb begin
        busy_d  = (busy_q != '0) ? busy_q - BUSY_W'(1) : busy_q;
        md_e1_d = 1'b0;
        if (!hz.flush && !stall_c && is_md) begin
            busy_d  = is_div ? BUSY_W'(DIV_CYC) : BUSY_W'(MULT_CYC);
            md_e1_d = 1'b1;
        end
    end

    // MDU busy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            md_e1_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            md_e1_q <= md_e1_d;
        end
    end
`else
    assign mdu_stall_c = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. An instruction-level model of the
// writer table predicts stall/fwd for every D-stage instruction driven.
module tb_hazard_ctrl;

    localparam int unsigned STAGES   = 3;
    localparam int unsigned TNEW_W   = 2;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    typedef enum int {
        K_NOP, K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_LOTBZ, K_MFC0, K_SW, K_MTC0,
        K_BEQ, K_JR, K_JAL, K_ERET, K_SYSCALL, K_MULT, K_DIV, K_MFLO, K_NKIND
    } kind_e;

    typedef struct {
        string tag;
        int    stall;
        int    frs;
        int    frt;
    } exp_t;

    logic clk;
    logic reset;

    hazard_ctrl_if #(.STAGES(STAGES)) hz ();

    hazard_ctrl #(
        .STAGES   (STAGES),
        .TNEW_W   (TNEW_W),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    int   m_dest [1:STAGES];
    int   m_tnew [1:STAGES];
    int   m_busy;
    int   m_md_e1;
    int   last_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= int'(STAGES); k++) begin
            m_dest[k] = 0;
            m_tnew[k] = 0;
        end
        m_busy  = 0;
        m_md_e1 = 0;
    endtask

    // Instruction semantics table: what each kind writes and when it needs operands
    task automatic kind_info(input kind_e k, input int rt, input int rd,
                             output int dest, output int tnew,
                             output int urs, output int trs, output int urt, output int trt,
                             output int md, output int mdu, output int cyc);
        dest = 0; tnew = 0; urs = 0; trs = 0; urt = 0; trt = 0; md = 0; mdu = 0; cyc = 0;
        case (k)
            K_ADD, K_SUB:  begin dest = rd; tnew = 1; urs = 1; trs = 1; urt = 1; trt = 1; end
            K_ORI, K_LUI:  begin dest = rt; tnew = 1; urs = 1; trs = 1; end
            K_LW, K_LOTBZ: begin dest = rt; tnew = 2; urs = 1; trs = 1; end
            K_MFC0:        begin dest = rt; tnew = 2; end
            K_SW:          begin urs = 1; trs = 1; urt = 1; trt = 2; end
            K_MTC0:        begin urt = 1; trt = 2; end
            K_BEQ:         begin urs = 1; trs = 0; urt = 1; trt = 0; end
            K_JR:          begin urs = 1; trs = 0; end
            K_JAL:         begin dest = 31; tnew = 0; end
`ifdef CTRL_MDU_EN
            K_MULT:        begin urs = 1; trs = 1; urt = 1; trt = 1; md = 1; mdu = 1; cyc = MULT_CYC; end
            K_DIV:         begin urs = 1; trs = 1; urt = 1; trt = 1; md = 1; mdu = 1; cyc = DIV_CYC; end
            K_MFLO:        begin dest = rd; tnew = 1; mdu = 1; end
`endif
            default: ;
        endcase
    endtask

    task automatic drive(input kind_e k, input int rs, input int rt, input int rd, input bit fl);
        logic [5:0] op, fn;
        logic [4:0] s, t, d;
        op = 6'd0; fn = 6'd0; s = 5'(rs); t = 5'(rt); d = 5'(rd);
        case (k)
            K_ADD:     fn = 6'b100000;
            K_SUB:     fn = 6'b100010;
            K_JR:      fn = 6'b001000;
            K_SYSCALL: begin fn = 6'b001100; s = 5'd0; t = 5'd0; d = 5'd0; end
            K_MULT:    fn = 6'b011000;
            K_DIV:     fn = 6'b011010;
            K_MFLO:    fn = 6'b010010;
            K_ORI:     op = 6'b001101;
            K_LUI:     op = 6'b001111;
            K_LW:      op = 6'b100011;
            K_LOTBZ:   op = 6'b111110;
            K_SW:      op = 6'b101011;
            K_BEQ:     op = 6'b000100;
            K_JAL:     op = 6'b000011;
            K_MFC0:    begin op = 6'b010000; s = 5'b00000; end
            K_MTC0:    begin op = 6'b010000; s = 5'b00100; end
            K_ERET:    begin op = 6'b010000; s = 5'b10000; t = 5'd0; d = 5'd0; fn = 6'b011000; end
            default:   begin s = 5'd0; t = 5'd0; d = 5'd0; end
        endcase
        hz.d_op   = op;
        hz.d_func = fn;
        hz.d_rs   = s;
        hz.d_rt   = t;
        hz.d_rd   = d;
        hz.flush  = fl;
    endtask

    function automatic int youngest_fwd(input int r, input int used);
        if (used == 0 || r == 0) return 0;
        for (int k = 1; k <= int'(STAGES); k++)
            if (m_dest[k] == r) return (m_tnew[k] == 0) ? k : 0;
        return 0;
    endfunction

    // One D-stage cycle: drive, predict, compare mid-cycle, then age the model
    task automatic step(input kind_e k, input int rs, input int rt, input int rd,
                        input bit fl, input string tag);
        exp_t e, got_e;
        int dest, tnew, urs, trs, urt, trt, md, mdu, cyc, st;
        @(negedge clk);
        drive(k, rs, rt, rd, fl);
        kind_info(k, rt, rd, dest, tnew, urs, trs, urt, trt, md, mdu, cyc);
        st = 0;
        for (int j = 1; j <= int'(STAGES); j++) begin
            if (urs != 0 && rs != 0 && m_dest[j] == rs && trs < m_tnew[j]) st = 1;
            if (urt != 0 && rt != 0 && m_dest[j] == rt && trt < m_tnew[j]) st = 1;
        end
        if (mdu != 0 && (m_busy != 0 || m_md_e1 != 0)) st = 1;
        e.tag   = tag;
        e.stall = st;
        e.frs   = youngest_fwd(rs, urs);
        e.frt   = youngest_fwd(rt, urt);
        sb.push_back(e);
        #1;
        got_e = sb.pop_front();
        chk({got_e.tag, ".stall"},  32'(hz.stall),  got_e.stall);
        chk({got_e.tag, ".fwd_rs"}, 32'(hz.fwd_rs), got_e.frs);
        chk({got_e.tag, ".fwd_rt"}, 32'(hz.fwd_rt), got_e.frt);
        last_stall = int'(hz.stall);
        @(posedge clk);
        if (fl) begin
            for (int j = 1; j <= int'(STAGES); j++) begin
                m_dest[j] = 0;
                m_tnew[j] = 0;
            end
        end else begin
            for (int j = int'(STAGES); j >= 2; j--) begin
                m_dest[j] = m_dest[j-1];
                m_tnew[j] = (m_tnew[j-1] > 0) ? m_tnew[j-1] - 1 : 0;
            end
            m_dest[1] = (st != 0) ? 0 : dest;
            m_tnew[1] = (st != 0) ? 0 : tnew;
        end
        if (!fl && st == 0 && md != 0) m_busy = cyc;
        else if (m_busy > 0)           m_busy = m_busy - 1;
        m_md_e1 = (!fl && st == 0 && md != 0) ? 1 : 0;
    endtask

    task automatic drain();
        for (int j = 0; j < int'(STAGES); j++) step(K_NOP, 0, 0, 0, 1'b0, "drain");
    endtask

    initial begin
        int n_mdu;
        kind_e rk;
        n_checks = 0;
        n_errors = 0;
        model_clear();
        reset = 1'b1;
        drive(K_NOP, 0, 0, 0, 1'b0);
        #2 reset = 1'b0;
        drive(K_ADD, 1, 2, 3, 1'b0);
        #3;
        chk("reset.stall",  32'(hz.stall),  0);
        chk("reset.fwd_rs", 32'(hz.fwd_rs), 0);
        chk("reset.fwd_rt", 32'(hz.fwd_rt), 0);
        drive(K_NOP, 0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // load-use: one stall, then issue
        step(K_LW,  4, 1, 0, 1'b0, "lw.issue");
        step(K_ADD, 1, 3, 2, 1'b0, "lw.use_stall");
        step(K_ADD, 1, 3, 2, 1'b0, "lw.use_go");
        drain();
        // branch needs operand at D
        step(K_ADD, 4, 5, 1, 1'b0, "beq.prod");
        step(K_BEQ, 1, 1, 0, 1'b0, "beq.stall");
        step(K_BEQ, 1, 1, 0, 1'b0, "beq.fwd_m");
        drain();
        // two writers of $5: youngest decides
        step(K_ADD, 4, 4, 5, 1'b0, "two.add5");
        step(K_ORI, 0, 5, 0, 1'b0, "two.ori5");
        step(K_SUB, 5, 0, 6, 1'b0, "two.young_busy");
        step(K_SUB, 5, 0, 6, 1'b0, "two.young_fwd");
        drain();
        // jal result ready in E
        step(K_JAL, 0, 0, 0, 1'b0, "jal.a");
        step(K_JAL, 0, 0, 0, 1'b0, "jal.b");
        step(K_JR, 31, 0, 0, 1'b0, "jr.fwd_e");
        drain();
        // register 0 never matches
        step(K_ADD, 1, 2, 0, 1'b0, "zero.w");
        step(K_ADD, 0, 0, 3, 1'b0, "zero.use");
        drain();
        // flush during stall
        step(K_LW,  4, 7, 0, 1'b0, "flush.lw");
        step(K_BEQ, 7, 7, 0, 1'b1, "flush.stall");
        step(K_BEQ, 7, 7, 0, 1'b0, "flush.clear");
        drain();
        // store / cp0 / lotbz / lui timing
        step(K_LW,    0, 9, 0, 1'b0, "sw.lw");
        step(K_SW,   10, 9, 0, 1'b0, "sw.rt_late");
        drain();
        step(K_LOTBZ, 0, 9, 0, 1'b0, "sw.lotbz");
        step(K_SW,    9, 10, 0, 1'b0, "sw.rs_stall");
        step(K_SW,    9, 10, 0, 1'b0, "sw.rs_go");
        drain();
        step(K_MFC0,  0, 11, 12, 1'b0, "mfc0.w");
        step(K_ADD,  11, 0, 12, 1'b0, "mfc0.stall");
        drain();
        step(K_LW,    0, 13, 0, 1'b0, "mtc0.lw");
        step(K_MTC0,  0, 13, 14, 1'b0, "mtc0.nostall");
        drain();
        step(K_LUI,   0, 16, 0, 1'b0, "lui.w");
        step(K_ORI,  16, 17, 0, 1'b0, "ori.after_lui");
        drain();
        // oldest entry forwards when nothing younger matches
        step(K_LW,  0, 13, 0, 1'b0, "deep.lw");
        step(K_NOP, 0, 0, 0, 1'b0, "deep.nop1");
        step(K_NOP, 0, 0, 0, 1'b0, "deep.nop2");
        step(K_ADD, 13, 0, 14, 1'b0, "deep.fwd_w");
        step(K_ERET, 0, 0, 0, 1'b0, "eret");
        step(K_SYSCALL, 0, 0, 0, 1'b0, "syscall");
        drain();

        // MDU interlock (absent in the default build)
        step(K_MULT, 1, 2, 0, 1'b0, "mdu.mult");
        n_mdu = 0;
        for (int i = 0; i < 20; i++) begin
            step(K_MFLO, 0, 0, 3, 1'b0, "mdu.mflo");
            if (last_stall == 0) break;
            n_mdu++;
        end
`ifdef CTRL_MDU_EN
        chk("mdu.stall_cycles", 32'(n_mdu), MULT_CYC);
`else
        chk("mdu.stall_cycles", 32'(n_mdu), 0);
`endif
        drain();

        // asynchronous reset while stalled
        step(K_LW, 4, 15, 0, 1'b0, "arst.lw");
        @(negedge clk);
        drive(K_ADD, 15, 15, 1, 1'b0);
        #1;
        chk("arst.pre_stall", 32'(hz.stall), 1);
        reset = 1'b0;
        #1;
        chk("arst.stall",  32'(hz.stall),  0);
        chk("arst.fwd_rs", 32'(hz.fwd_rs), 0);
        chk("arst.fwd_rt", 32'(hz.fwd_rt), 0);
        model_clear();
        @(negedge clk);
        drive(K_NOP, 0, 0, 0, 1'b0);
        reset = 1'b1;

        // random mix over a small register set to provoke overlaps
        for (int i = 0; i < 80; i++) begin
            rk = kind_e'($urandom_range(0, int'(K_NKIND) - 1));
            step(rk, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
